// File: rtl/mul_arbiter_pkg.sv
// Shared types for the two-requester multiplier arbiter: FSM state encoding,
// default datapath width and the two-way round-robin pick rule.
package mul_arbiter_pkg;

  localparam int unsigned MUL_N_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // A lone requester always wins; on a tie the pointer names the winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] val, input logic ptr);
    logic [1:0] grant;
    grant = 2'b00;
    if (val == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = val;
    end
    return grant;
  endfunction

endpackage

// File: rtl/mul_rr_grant.sv
// Two-way round-robin picker: one-hot grant from the request vector and the
// current priority pointer. Purely combinational.
module mul_rr_grant
  import mul_arbiter_pkg::*;
(
  input  logic [1:0] val,
  input  logic       ptr,
  output logic [1:0] grant
);

  assign grant = rr_pick(val, ptr);

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier between two requesters, one transaction in flight.
// Operands and result are held in registers so every handshake can stall freely.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned N = MUL_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         req0_val,
  output logic         req0_rdy,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,

  input  logic         req1_val,
  output logic         req1_rdy,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,

  output logic         resp0_val,
  input  logic         resp0_rdy,
  output logic         resp1_val,
  input  logic         resp1_rdy,
  output logic [N-1:0] resp_c,

  output logic         mul_recv_val,
  input  logic         mul_recv_rdy,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,

  input  logic         mul_send_val,
  output logic         mul_send_rdy,
  input  logic [N-1:0] mul_c
);

  arb_state_t   state;
  logic         ptr;
  logic         owner;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N-1:0] c_q;

  // One-hot strobes registered alongside the state so outputs come from flops.
  logic         issue_q;
  logic         wait_q;
  logic         resp_q;

  logic [1:0]   grant;
  logic         idle_ok;
  logic         accept;
  logic         winner;
  logic         resp_fire;

  mul_rr_grant u_grant (
    .val   ({req1_val, req0_val}),
    .ptr   (ptr),
    .grant (grant)
  );

  // NOTE: reset is synchronous, so state only clears at the edge; every output
  // is also masked with reset so nothing leaks out during the reset cycle itself.
  assign idle_ok   = (state == IDLE) && !reset;
  assign req0_rdy  = idle_ok && grant[0];
  assign req1_rdy  = idle_ok && grant[1];
  assign accept    = (req0_val && req0_rdy) || (req1_val && req1_rdy);
  assign winner    = grant[1];
  assign resp_fire = resp_q && (owner ? resp1_rdy : resp0_rdy);

  assign mul_recv_val = issue_q && !reset;
  assign mul_send_rdy = wait_q && !reset;
  assign resp0_val    = resp_q && !owner && !reset;
  assign resp1_val    = resp_q && owner && !reset;

  assign mul_a  = reset ? '0 : a_q;
  assign mul_b  = reset ? '0 : b_q;
  assign resp_c = reset ? '0 : c_q;

  // NOTE: all state lives in this one block and uses non-blocking assignments,
  // so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      // NOTE: operand/result registers are cleared too, so mul_a/mul_b/resp_c
      // read zero after reset rather than a stale abandoned transaction.
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      issue_q <= 1'b0;
      wait_q  <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner   <= winner;
            a_q     <= winner ? req1_a : req0_a;
            b_q     <= winner ? req1_b : req0_b;
            state   <= ISSUE;
            issue_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (mul_recv_rdy) begin
            state   <= WAIT;
            issue_q <= 1'b0;
            wait_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (mul_send_val) begin
            c_q    <= mul_c;
            state  <= RESP;
            wait_q <= 1'b0;
            resp_q <= 1'b1;
          end
        end
        RESP: begin
          // Hand priority to the other requester only once the result is taken.
          if (resp_fire) begin
            state  <= IDLE;
            resp_q <= 1'b0;
            ptr    <= ~owner;
          end
        end
        default: begin
          state   <= IDLE;
          issue_q <= 1'b0;
          wait_q  <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N, default 6, operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_val / req1_val  input  1 each  requester i presents operands.
REQ-005 req0_rdy / req1_rdy  output  1 each  arbiter accepts requester i operands this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N each  operands of requester i.
REQ-007 resp0_val / resp1_val  output  1 each  result valid for requester i.
REQ-008 resp0_rdy / resp1_rdy  input  1 each  requester i accepts result.
REQ-009 resp_c  output  N  result shared by both response ports, valid only with respi_val.
REQ-010 mul_recv_val  output  1  operands valid to multiplier.
REQ-011 mul_recv_rdy  input  1  multiplier accepts operands.
REQ-012 mul_a, mul_b  output  N each  operands to multiplier.
REQ-013 mul_send_val  input  1  multiplier result valid.
REQ-014 mul_send_rdy  output  1  arbiter accepts multiplier result.
REQ-015 mul_c  input  N  multiplier result.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; one transaction in flight at most.
REQ-017 In IDLE, reqi_rdy SHALL be 1 only for the granted requester i, combinationally; all other rdy outputs SHALL be 0.
REQ-018 Grant: if only one reqi_val=1, that requester wins; if both are 1, the requester selected by the priority pointer wins.
REQ-019 On accept (reqi_val&reqi_rdy), operands and owner ID SHALL be registered and the state SHALL go to ISSUE next cycle.
REQ-020 ISSUE: mul_recv_val=1, mul_a/mul_b = registered operands; on mul_recv_rdy=1 go to WAIT.
REQ-021 WAIT: mul_send_rdy=1; on mul_send_val=1 register mul_c and go to RESP.
REQ-022 RESP: resp<owner>_val=1, resp_c = registered result; on resp<owner>_rdy=1 go to IDLE.
REQ-023 The priority pointer SHALL change to the non-owner only on RESP completion; it SHALL stay unchanged otherwise.
REQ-024 mul_recv_val, mul_send_rdy and respi_val SHALL be 0 outside their stated states.
REQ-025 Minimum latency: accept at cycle t, earliest respi_val at t+3 (multiplier latency excluded).
REQ-026 A request arriving while the arbiter is not in IDLE SHALL stall with reqi_rdy=0 and is never dropped.
REQ-027 Backpressure at any stage (mul_recv_rdy=0, mul_send_val=0, respi_rdy=0) SHALL hold state and registers indefinitely.
REQ-028 resp_c SHALL be mul_c unmodified; the arbiter performs no arithmetic.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, priority pointer=0, owner=0, and operand/result registers=0.
REQ-030 While reset=1: all val/rdy outputs SHALL be 0 and resp_c, mul_a and mul_b SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no response.

Structure
REQ-032 A shared package SHALL hold the state enum typedef and the default N.
REQ-033 A sub-module mul_rr_grant (2-way round-robin picker: inputs val[1:0] and pointer, output one-hot grant) is natural.

Verification
REQ-034 Single request: req0 a=5, b=7 -> resp0_val with resp_c = 35, resp1_val never asserted.
REQ-035 Simultaneous requests after reset: req0 (3×4) and req1 (2×9) -> req0 served first (resp_c=12), then req1 (resp_c=18).
REQ-036 Fairness: both requesters hold valid for 4 transactions -> grants alternate 0,1,0,1.
REQ-037 Backpressure: resp0_rdy=0 for 5 cycles with a=9, b=9 -> resp0_val and resp_c = 17 (low 6 bits) stable all 5 cycles, and req1_rdy=0 throughout.
REQ-038 Reset during WAIT -> next cycle all outputs 0, state IDLE, and a subsequent req1 (6×6) -> resp_c = 36.
